exu_lsu: RTL and testbench

- Load/store unit directly downstream of the execute-stage address generation unit (AGU).
- Accepts one decoded memory access per handshake: address, aligned write data, byte enables, read strobe.
- Runs it as a single outstanding transaction on the core data-memory bus: request/grant, then response.
- Returns the raw 32-bit read word and completion ready to the AGU, which does byte/half extraction and sign extension.

---
 rtl/exu_lsu_if.sv | 25 ++
 rtl/exu_lsu.sv | 137 +++++++++++++
 tb/tb_exu_lsu.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/exu_lsu_if.sv
// Core data-memory bus between the load/store unit (master) and the memory side (slave).
interface exu_lsu_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          o_mem_req;
   logic          i_mem_gnt;
   logic [AW-1:0] o_mem_adr;
   logic [DW-1:0] o_mem_wdat;
   logic [3:0]    o_mem_wen;
   logic          o_mem_ren;
   logic          i_mem_rvld;
   logic [DW-1:0] i_mem_rdat;
   logic          i_mem_err;

   modport master (
      output o_mem_req, o_mem_adr, o_mem_wdat, o_mem_wen, o_mem_ren,
      input  i_mem_gnt, i_mem_rvld, i_mem_rdat, i_mem_err
   );

   modport slave (
      input  o_mem_req, o_mem_adr, o_mem_wdat, o_mem_wen, o_mem_ren,
      output i_mem_gnt, i_mem_rvld, i_mem_rdat, i_mem_err
   );
endinterface

// File: rtl/exu_lsu.sv
// Single-outstanding load/store unit between the AGU handshake and the data-memory bus.
// Optional response timeout is enabled by defining CIRNO_LSU_TIMEOUT_EN.
module exu_lsu #(
   parameter int AW     = 32,
   parameter int DW     = 32,
   parameter int TO_CYC = 255,
   parameter int TO_W   = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          hs_ag4ls_val,
   output logic          hs_ls4ag_rdy,
   input  logic [AW-1:0] i_ls_adr,
   input  logic [DW-1:0] i_ls_wdat,
   input  logic [3:0]    i_ls_wen,
   input  logic          i_ls_ren,
   output logic [DW-1:0] o_ls_rdat,
   output logic          o_ls_err,
   exu_lsu_if.master     mem,
   output logic          o_busy
);

   typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [AW-3:0] adr_q;
   logic [DW-1:0] wdat_q;
   logic [3:0]    wen_q;
   logic          ren_q;
   logic [DW-1:0] rdat_q;
   logic          err_q;
   logic          mem_op;
   logic          accept;
   logic          rsp_take;
   logic          to_hit;
   logic          unused_adr_lo;

   assign mem_op        = i_ls_ren | (|i_ls_wen);
   assign accept        = (state == IDLE) && hs_ag4ls_val && mem_op;
   assign rsp_take      = (state == RSP) && mem.i_mem_rvld;
   assign unused_adr_lo = ^i_ls_adr[1:0];

`ifdef CIRNO_LSU_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt;

   // Count silent RSP cycles; REQ always precedes RSP, so clearing there covers entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt <= '0;
      end else if (state == REQ) begin
         to_cnt <= '0;
      end else if ((state == RSP) && !mem.i_mem_rvld) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   assign to_hit = (state == RSP) && !mem.i_mem_rvld && (to_cnt == TO_W'(TO_CYC - 1));
`else
   logic [TO_W-1:0] unused_to;

   assign unused_to = TO_W'(TO_CYC);
   assign to_hit    = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         adr_q  <= '0;
         wdat_q <= '0;
         wen_q  <= '0;
         ren_q  <= 1'b0;
         rdat_q <= '0;
         err_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            adr_q  <= i_ls_adr[AW-1:2];
            wdat_q <= i_ls_wdat;
            wen_q  <= i_ls_wen;
            // A request carrying both strobes is executed as a write.
            ren_q  <= i_ls_ren & ~(|i_ls_wen);
         end
         if (rsp_take) begin
            rdat_q <= (|wen_q) ? '0 : mem.i_mem_rdat;
            err_q  <= mem.i_mem_err;
         end else if (to_hit) begin
            rdat_q <= '0;
            err_q  <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (accept) state_nxt = REQ;
         REQ:  if (mem.i_mem_gnt) state_nxt = RSP;
         RSP:  if (rsp_take || to_hit) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      hs_ls4ag_rdy   = 1'b0;
      o_ls_rdat      = '0;
      o_ls_err       = 1'b0;
      mem.o_mem_req  = 1'b0;
      mem.o_mem_adr  = '0;
      mem.o_mem_wdat = '0;
      mem.o_mem_wen  = '0;
      mem.o_mem_ren  = 1'b0;
      unique case (state)
         IDLE: begin
            // Non-memory instructions share the execute handshake and complete at once.
            if (hs_ag4ls_val && !mem_op) hs_ls4ag_rdy = 1'b1;
         end
         REQ: begin
            mem.o_mem_req  = 1'b1;
            mem.o_mem_adr  = {adr_q, 2'b00};
            mem.o_mem_wdat = wdat_q;
            mem.o_mem_wen  = wen_q;
            mem.o_mem_ren  = ren_q;
         end
         DONE: begin
            hs_ls4ag_rdy = 1'b1;
            o_ls_rdat    = rdat_q;
            o_ls_err     = err_q;
         end
         default: ;
      endcase
   end

   assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_exu_lsu.sv
// Directed self-checking bench for exu_lsu; inputs change and outputs are sampled around the falling edge.
module tb_exu_lsu;

   localparam int AW = 32;
   localparam int DW = 32;
`ifdef CIRNO_LSU_TIMEOUT_EN
   localparam int TO_CYC = 4;
`else
   localparam int TO_CYC = 255;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          agVal;
   logic          lsRdy;
   logic [AW-1:0] lsAdr;
   logic [DW-1:0] lsWdat;
   logic [3:0]    lsWen;
   logic          lsRen;
   logic [DW-1:0] lsRdat;
   logic          lsErr;
   logic          busy;
   int            assertCount = 0;
   int            failCount   = 0;
   int            rdyCount;

   exu_lsu_if #(.AW(AW), .DW(DW)) memBus ();

   exu_lsu #(.AW(AW), .DW(DW), .TO_CYC(TO_CYC), .TO_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .hs_ag4ls_val (agVal),
      .hs_ls4ag_rdy (lsRdy),
      .i_ls_adr     (lsAdr),
      .i_ls_wdat    (lsWdat),
      .i_ls_wen     (lsWen),
      .i_ls_ren     (lsRen),
      .o_ls_rdat    (lsRdat),
      .o_ls_err     (lsErr),
      .mem          (memBus.master),
      .o_busy       (busy)
   );

   always #5 clk = ~clk;

   // Every comparison funnels through here so the counters stay honest.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] we, input logic re);
      agVal  = v;
      lsAdr  = a;
      lsWdat = wd;
      lsWen  = we;
      lsRen  = re;
   endtask

   task automatic driveBus(input logic g, input logic rv, input logic [31:0] rd, input logic er);
      memBus.i_mem_gnt  = g;
      memBus.i_mem_rvld = rv;
      memBus.i_mem_rdat = rd;
      memBus.i_mem_err  = er;
   endtask

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      driveBus(1'b0, 1'b0, 32'h0, 1'b0);
      #2;
      checkOutput("rst_busy", {31'b0, busy}, 32'h0);
      checkOutput("rst_req", {31'b0, memBus.o_mem_req}, 32'h0);
      checkOutput("rst_rdy", {31'b0, lsRdy}, 32'h0);
      checkOutput("rst_adr", memBus.o_mem_adr, 32'h0);
      checkOutput("rst_rdat", lsRdat, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Zero-wait load: rdy lands three cycles after val.
      applyStimulus(1'b1, 32'h0000_1006, 32'h0, 4'h0, 1'b1);
      #1;
      checkOutput("ld_t0_rdy", {31'b0, lsRdy}, 32'h0);
      checkOutput("ld_t0_req", {31'b0, memBus.o_mem_req}, 32'h0);
      @(negedge clk);
      driveBus(1'b1, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("ld_req", {31'b0, memBus.o_mem_req}, 32'h1);
      checkOutput("ld_adr", memBus.o_mem_adr, 32'h0000_1004);
      checkOutput("ld_ren", {31'b0, memBus.o_mem_ren}, 32'h1);
      checkOutput("ld_wen", {28'b0, memBus.o_mem_wen}, 32'h0);
      checkOutput("ld_busy", {31'b0, busy}, 32'h1);
      @(negedge clk);
      driveBus(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
      #1;
      checkOutput("ld_rsp_req", {31'b0, memBus.o_mem_req}, 32'h0);
      checkOutput("ld_rsp_rdy", {31'b0, lsRdy}, 32'h0);
      @(negedge clk);
      driveBus(1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("ld_done_rdy", {31'b0, lsRdy}, 32'h1);
      checkOutput("ld_done_rdat", lsRdat, 32'hDEAD_BEEF);
      checkOutput("ld_done_err", {31'b0, lsErr}, 32'h0);
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      @(negedge clk);
      #1;
      checkOutput("ld_after_rdy", {31'b0, lsRdy}, 32'h0);
      checkOutput("ld_after_busy", {31'b0, busy}, 32'h0);

      // Store with a three-cycle grant stall; the address phase must hold steady.
      applyStimulus(1'b1, 32'h0000_2002, 32'h1234_0000, 4'b1100, 1'b0);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         driveBus(i == 3, 1'b0, 32'h0, 1'b0);
         #1;
         checkOutput($sformatf("st_req_%0d", i), {31'b0, memBus.o_mem_req}, 32'h1);
         checkOutput($sformatf("st_adr_%0d", i), memBus.o_mem_adr, 32'h0000_2000);
         checkOutput($sformatf("st_wdat_%0d", i), memBus.o_mem_wdat, 32'h1234_0000);
         checkOutput($sformatf("st_wen_%0d", i), {28'b0, memBus.o_mem_wen}, 32'hC);
         checkOutput($sformatf("st_ren_%0d", i), {31'b0, memBus.o_mem_ren}, 32'h0);
         @(negedge clk);
      end
      driveBus(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
      #1;
      checkOutput("st_rsp_rdy", {31'b0, lsRdy}, 32'h0);
      @(negedge clk);
      driveBus(1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("st_done_rdy", {31'b0, lsRdy}, 32'h1);
      checkOutput("st_done_rdat", lsRdat, 32'h0);
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      @(negedge clk);

      // Non-memory op completes combinationally without touching the bus.
      applyStimulus(1'b1, 32'h0000_3000, 32'h0000_0055, 4'h0, 1'b0);
      #1;
      checkOutput("nm_rdy", {31'b0, lsRdy}, 32'h1);
      checkOutput("nm_rdat", lsRdat, 32'h0);
      checkOutput("nm_req", {31'b0, memBus.o_mem_req}, 32'h0);
      @(negedge clk);
      #1;
      checkOutput("nm_busy", {31'b0, busy}, 32'h0);
      checkOutput("nm_req2", {31'b0, memBus.o_mem_req}, 32'h0);
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      #1;
      checkOutput("nm_rdy_off", {31'b0, lsRdy}, 32'h0);
      @(negedge clk);

      // Both strobes set: handled as a write.
      applyStimulus(1'b1, 32'h0000_4000, 32'h0000_AABB, 4'b0011, 1'b1);
      @(negedge clk);
      driveBus(1'b1, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("ill_ren", {31'b0, memBus.o_mem_ren}, 32'h0);
      checkOutput("ill_wen", {28'b0, memBus.o_mem_wen}, 32'h3);
      @(negedge clk);
      driveBus(1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
      @(negedge clk);
      driveBus(1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("ill_rdy", {31'b0, lsRdy}, 32'h1);
      checkOutput("ill_rdat", lsRdat, 32'h0);
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      @(negedge clk);

      // Bus error, preceded by a spurious rvld while waiting for grant.
      applyStimulus(1'b1, 32'h0000_5008, 32'h0, 4'h0, 1'b1);
      @(negedge clk);
      driveBus(1'b0, 1'b1, 32'h1111_1111, 1'b0);
      #1;
      checkOutput("er_req0", {31'b0, memBus.o_mem_req}, 32'h1);
      @(negedge clk);
      driveBus(1'b1, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("er_req1", {31'b0, memBus.o_mem_req}, 32'h1);
      @(negedge clk);
      driveBus(1'b0, 1'b1, 32'h0, 1'b1);
      #1;
      checkOutput("er_rsp_rdy", {31'b0, lsRdy}, 32'h0);
      @(negedge clk);
      driveBus(1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("er_rdy", {31'b0, lsRdy}, 32'h1);
      checkOutput("er_err", {31'b0, lsErr}, 32'h1);
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      @(negedge clk);

      // Follow-up load: error clears; val drops mid-flight and a response wait is inserted.
      applyStimulus(1'b1, 32'h0000_600C, 32'h0, 4'h0, 1'b1);
      @(negedge clk);
      driveBus(1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      driveBus(1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("vd_busy", {31'b0, busy}, 32'h1);
      checkOutput("vd_wait_rdy", {31'b0, lsRdy}, 32'h0);
      @(negedge clk);
      driveBus(1'b0, 1'b1, 32'h0BAD_F00D, 1'b0);
      @(negedge clk);
      driveBus(1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("vd_rdy", {31'b0, lsRdy}, 32'h1);
      checkOutput("vd_rdat", lsRdat, 32'h0BAD_F00D);
      checkOutput("vd_err", {31'b0, lsErr}, 32'h0);
      @(negedge clk);

      // Reset during RSP, then a late rvld must be ignored.
      applyStimulus(1'b1, 32'h0000_7000, 32'h0, 4'h0, 1'b1);
      @(negedge clk);
      driveBus(1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      driveBus(1'b0, 1'b0, 32'h0, 1'b0);
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      rst = 1'b1;
      #1;
      checkOutput("rm_req", {31'b0, memBus.o_mem_req}, 32'h0);
      checkOutput("rm_busy", {31'b0, busy}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      driveBus(1'b0, 1'b1, 32'h1234_5678, 1'b0);
      #1;
      checkOutput("rm_rvld_rdy", {31'b0, lsRdy}, 32'h0);
      @(negedge clk);
      driveBus(1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("rm_after_rdy", {31'b0, lsRdy}, 32'h0);
      checkOutput("rm_after_busy", {31'b0, busy}, 32'h0);

      // Granted load that never gets a response.
      applyStimulus(1'b1, 32'h0000_8000, 32'h0, 4'h0, 1'b1);
      @(negedge clk);
      driveBus(1'b1, 1'b0, 32'h0, 1'b0);
      @(negedge clk);
      driveBus(1'b0, 1'b0, 32'h0, 1'b0);
`ifdef CIRNO_LSU_TIMEOUT_EN
      for (int i = 0; i < TO_CYC; i++) begin
         #1;
         checkOutput($sformatf("to_wait_rdy_%0d", i), {31'b0, lsRdy}, 32'h0);
         @(negedge clk);
      end
      #1;
      checkOutput("to_rdy", {31'b0, lsRdy}, 32'h1);
      checkOutput("to_err", {31'b0, lsErr}, 32'h1);
      checkOutput("to_rdat", lsRdat, 32'h0);
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      @(negedge clk);
      driveBus(1'b0, 1'b1, 32'h5555_AAAA, 1'b0);
      #1;
      checkOutput("to_stray_rdy", {31'b0, lsRdy}, 32'h0);
      @(negedge clk);
      driveBus(1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("to_stray_rdy2", {31'b0, lsRdy}, 32'h0);
      checkOutput("to_stray_busy", {31'b0, busy}, 32'h0);
`else
      rdyCount = 0;
      repeat (300) begin
         @(negedge clk);
         #1;
         if (lsRdy) rdyCount++;
      end
      checkOutput("nto_rdy_count", rdyCount, 32'h0);
      checkOutput("nto_busy", {31'b0, busy}, 32'h1);
      driveBus(1'b0, 1'b1, 32'hFEED_FACE, 1'b0);
      @(negedge clk);
      driveBus(1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput("nto_rdy", {31'b0, lsRdy}, 32'h1);
      checkOutput("nto_rdat", lsRdat, 32'hFEED_FACE);
      applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      @(negedge clk);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
